la_ioringseq: RTL and testbench

- Synchronous power-up/power-down sequencer for the generic pad-ring control bus shared by all ring cells (supply, ground, analog supply/ground, IO cells).
- Sits upstream of the ring cells. Its ring_ctrl output drives the ioring[RINGW-1:0] interface.
- Turns ring control lines on one at a time, in order, after the IO supply is reported good. Turns them off in reverse order.
- Forces all lines off immediately if the supply is lost.

---
 rtl/la_ioringseq.sv | 193 +++++++++++++++++++
 tb/tb_la_ioringseq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/la_ioringseq.sv
// la_ioringseq: power-up/power-down sequencer for the pad-ring control bus.
// Turns ring control lines on one at a time (bit 0 first) once the IO supply
// is good, turns them off in reverse order, and drops everything at once if
// the supply is lost.
//
// Ports:
//   clk        core clock
//   nreset     asynchronous active-low reset
//   en         sequence request (asynchronous): 1 = ring on, 0 = ring off
//   vddio_ok   IO supply good (asynchronous)
//   ring_ctrl  thermometer-coded control lines to the ioring
//   ready      ring fully enabled
//   fault      sticky supply-loss / timeout flag, cleared by dropping en
//   busy       ramping up or down
//
// Optional: define LA_IORINGSEQ_TIMEOUT_EN to fault out of WAIT when the
// supply is not good within TIMEOUT cycles.
module la_ioringseq #(
    parameter int unsigned RINGW   = 8,
    parameter int unsigned DELAY   = 16,
    parameter int unsigned CNTW    = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             en,
    input  logic             vddio_ok,
    output logic [RINGW-1:0] ring_ctrl,
    output logic             ready,
    output logic             fault,
    output logic             busy
);

    localparam logic [CNTW-1:0] DLY_LAST = CNTW'(DELAY - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        RAMPUP = 3'd2,
        ON     = 3'd3,
        RAMPDN = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNTW-1:0]  cnt, cnt_nxt;
    logic [RINGW-1:0] ring_nxt;
    logic             fault_nxt, ready_nxt, busy_nxt;
    logic             en_meta, en_s, ok_meta, ok_s;

    // Two-flop synchronisers for the asynchronous request and supply status
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            en_meta <= 1'b0;
            en_s    <= 1'b0;
            ok_meta <= 1'b0;
            ok_s    <= 1'b0;
        end else begin
            en_meta <= en;
            en_s    <= en_meta;
            ok_meta <= vddio_ok;
            ok_s    <= ok_meta;
        end
    end

`ifdef LA_IORINGSEQ_TIMEOUT_EN
    localparam logic [CNTW-1:0] TO_LAST = CNTW'(TIMEOUT - 1);
    logic [CNTW-1:0] wcnt, wcnt_nxt;

    // Wait-for-supply counter; only runs while in WAIT
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) wcnt <= '0;
        else         wcnt <= wcnt_nxt;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^CNTW'(TIMEOUT);
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            cnt       <= '0;
            ring_ctrl <= '0;
            ready     <= 1'b0;
            fault     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ring_ctrl <= ring_nxt;
            ready     <= ready_nxt;
            fault     <= fault_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ring_nxt  = ring_ctrl;
        fault_nxt = fault;
`ifdef LA_IORINGSEQ_TIMEOUT_EN
        wcnt_nxt  = '0;
`endif
        case (state)
            IDLE: begin
                ring_nxt = '0;
                cnt_nxt  = '0;
                if (fault) begin
                    if (!en_s) fault_nxt = 1'b0;
                end else if (en_s) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                ring_nxt = '0;
                cnt_nxt  = '0;
                if (!en_s) begin
                    state_nxt = IDLE;
                end else if (ok_s) begin
                    state_nxt = RAMPUP;
                end
`ifdef LA_IORINGSEQ_TIMEOUT_EN
                else if (wcnt == TO_LAST) begin
                    state_nxt = IDLE;
                    fault_nxt = 1'b1;
                end else begin
                    wcnt_nxt = wcnt + CNTW'(1);
                end
`endif
            end
            RAMPUP: begin
                if (!ok_s) begin
                    state_nxt = IDLE;
                    ring_nxt  = '0;
                    cnt_nxt   = '0;
                    fault_nxt = 1'b1;
                end else if (!en_s) begin
                    state_nxt = RAMPDN;
                    cnt_nxt   = '0;
                end else if (ring_ctrl[RINGW-1]) begin
                    state_nxt = ON;
                    cnt_nxt   = '0;
                end else if (cnt == DLY_LAST) begin
                    // shift in a one: keeps the bus thermometer-coded
                    ring_nxt = (ring_ctrl << 1) | RINGW'(1);
                    cnt_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + CNTW'(1);
                end
            end
            ON: begin
                if (!ok_s) begin
                    state_nxt = IDLE;
                    ring_nxt  = '0;
                    cnt_nxt   = '0;
                    fault_nxt = 1'b1;
                end else if (!en_s) begin
                    state_nxt = RAMPDN;
                    cnt_nxt   = '0;
                end
            end
            RAMPDN: begin
                // en_s is deliberately ignored here; ramp-down always completes
                if (!ok_s) begin
                    state_nxt = IDLE;
                    ring_nxt  = '0;
                    cnt_nxt   = '0;
                    fault_nxt = 1'b1;
                end else if (ring_ctrl == '0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DLY_LAST) begin
                    // drop the highest set bit
                    ring_nxt = ring_ctrl >> 1;
                    cnt_nxt  = '0;
                end else begin
                    cnt_nxt = cnt + CNTW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                ring_nxt  = '0;
                cnt_nxt   = '0;
            end
        endcase
        ready_nxt = (state_nxt == ON);
        busy_nxt  = (state_nxt == RAMPUP) || (state_nxt == RAMPDN);
    end

endmodule

// File: tb/tb_la_ioringseq.sv
// Directed testbench for la_ioringseq (RINGW=8, DELAY=4, TIMEOUT=10).
module tb_la_ioringseq;

    localparam int unsigned RINGW   = 8;
    localparam int unsigned DELAY   = 4;
    localparam int unsigned CNTW    = 8;
    localparam int unsigned TIMEOUT = 10;

    logic             clk;
    logic             nreset;
    logic             en;
    logic             vddio_ok;
    logic [RINGW-1:0] ring_ctrl;
    logic             ready;
    logic             fault;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    la_ioringseq #(
        .RINGW  (RINGW),
        .DELAY  (DELAY),
        .CNTW   (CNTW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .nreset   (nreset),
        .en       (en),
        .vddio_ok (vddio_ok),
        .ring_ctrl(ring_ctrl),
        .ready    (ready),
        .fault    (fault),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // advance n rising edges, ending on a falling edge
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // From IDLE with fault clear: request the ring and follow the full ramp-up.
    // 2 sync + 1 IDLE->WAIT + 1 WAIT->RAMPUP edges, then bit k at (k+1)*DELAY.
    task automatic ramp_up(input string tag);
        en       = 1'b1;
        vddio_ok = 1'b1;
        tick(3);
        check({tag, "_busy_wait"}, 32'(busy), 32'd0);
        tick(1);
        check({tag, "_busy_ramp"}, 32'(busy), 32'd1);
        tick(DELAY - 1);
        check({tag, "_ring_pre"}, 32'(ring_ctrl), 32'h00);
        tick(1);
        check({tag, "_ring_b0"}, 32'(ring_ctrl), 32'h01);
        for (int k = 1; k < RINGW; k++) begin
            tick(DELAY);
            check({tag, "_ring_step"}, 32'(ring_ctrl), (32'd1 << (k + 1)) - 32'd1);
            check({tag, "_ready_ramp"}, 32'(ready), 32'd0);
        end
        tick(1);
        check({tag, "_ready_on"}, 32'(ready), 32'd1);
        check({tag, "_busy_on"}, 32'(busy), 32'd0);
        check({tag, "_fault_on"}, 32'(fault), 32'd0);
    endtask

    initial begin
        nreset   = 1'b0;
        en       = 1'b0;
        vddio_ok = 1'b1;
        tick(2);
        check("rst_ring", 32'(ring_ctrl), 32'h00);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        nreset = 1'b1;
        tick(4);

        // Normal ramp-up
        ramp_up("up1");

        // Ramp-down from ON: RAMPDN entered 3 edges after en falls
        en = 1'b0;
        tick(3);
        check("dn_ready", 32'(ready), 32'd0);
        check("dn_busy", 32'(busy), 32'd1);
        check("dn_ring_full", 32'(ring_ctrl), 32'hFF);
        for (int k = RINGW - 1; k >= 0; k--) begin
            tick(DELAY);
            check("dn_ring_step", 32'(ring_ctrl), (32'd1 << k) - 32'd1);
        end
        tick(1);
        check("dn_busy_idle", 32'(busy), 32'd0);
        check("dn_fault", 32'(fault), 32'd0);
        tick(3);

        // Supply loss mid-ramp at ring_ctrl = 0x07 (edge 8 + 2*DELAY)
        en = 1'b1;
        tick(8 + 2 * DELAY);
        check("loss_ring_pre", 32'(ring_ctrl), 32'h07);
        vddio_ok = 1'b0;
        tick(3);
        check("loss_ring", 32'(ring_ctrl), 32'h00);
        check("loss_fault", 32'(fault), 32'd1);
        check("loss_busy", 32'(busy), 32'd0);
        vddio_ok = 1'b1;
        tick(20);
        check("loss_sticky", 32'(fault), 32'd1);
        check("loss_sticky_ring", 32'(ring_ctrl), 32'h00);
        en = 1'b0;
        tick(2);
        check("loss_fault_hold", 32'(fault), 32'd1);
        tick(1);
        check("loss_fault_clr", 32'(fault), 32'd0);
        tick(2);
        ramp_up("up2");

        // Re-request during ramp-down at ring_ctrl = 0x3F
        en = 1'b0;
        tick(3 + 2 * DELAY);
        check("rr_ring_3f", 32'(ring_ctrl), 32'h3F);
        en = 1'b1;
        tick(6 * DELAY);
        check("rr_ring_zero", 32'(ring_ctrl), 32'h00);
        check("rr_ready", 32'(ready), 32'd0);
        check("rr_busy_dn", 32'(busy), 32'd1);
        tick(1);
        check("rr_busy_idle", 32'(busy), 32'd0);
        tick(2 + DELAY);
        check("rr_ring_b0", 32'(ring_ctrl), 32'h01);
        tick((RINGW - 1) * DELAY);
        check("rr_ring_full", 32'(ring_ctrl), 32'hFF);
        tick(1);
        check("rr_ready_on", 32'(ready), 32'd1);

        // Asynchronous reset while ON, then release with en and supply held
        #2 nreset = 1'b0;
        #1;
        check("arst_ring", 32'(ring_ctrl), 32'h00);
        check("arst_ready", 32'(ready), 32'd0);
        check("arst_fault", 32'(fault), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        tick(2);
        nreset = 1'b1;
        ramp_up("up3");

        // Supply never good while requesting
        en = 1'b0;
        tick(40);
        vddio_ok = 1'b0;
        tick(3);
        en = 1'b1;
`ifdef LA_IORINGSEQ_TIMEOUT_EN
        tick(3 + TIMEOUT - 1);
        check("to_fault_pre", 32'(fault), 32'd0);
        tick(1);
        check("to_fault", 32'(fault), 32'd1);
        check("to_ring", 32'(ring_ctrl), 32'h00);
`else
        tick(60);
        check("noto_fault", 32'(fault), 32'd0);
        check("noto_ring", 32'(ring_ctrl), 32'h00);
        check("noto_busy", 32'(busy), 32'd0);
`endif
        en = 1'b0;
        tick(4);
        check("end_fault", 32'(fault), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
